dr_word_serializer: RTL and testbench
=====================================

Name: dr_word_serializer

Overview:
- Clocked front-end stage that feeds the asynchronous dual-rail multiple-of-three detector.
- Accepts a parallel word via a valid/ready handshake and serializes it MSB-first as dual-rail tokens on in0/in1.
- Each token completes a four-phase return-to-zero handshake, using the detector's parity0/parity1 rails as acknowledge.
- Reports the detector's response to the final bit of each word.

Parameters:
- WIDTH, 8, bits per word (≥1).
- TIMEOUT, 255, max clk cycles allowed in any wait state before error (≥4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- word_in  input  WIDTH  word to serialize.
- word_valid  input  1  word_in valid.
- word_ready  output  1  block can accept a word.
- in0  output  1  dual-rail data rail, bit value 0.
- in1  output  1  dual-rail data rail, bit value 1.
- parity0  input  1  detector acknowledge rail 0 (asynchronous).
- parity1  input  1  detector acknowledge rail 1 (asynchronous).
- result_valid  output  1  one-cycle pulse: word complete.
- result_p1  output  1  1 if the final token was acked on parity1; 0 if on parity0.
- err  output  1  sticky protocol/timeout error, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in0=in1=0; word_ready=0; result_valid=0; result_p1=0; err=0; shift register, bit counter, timeout counter and synchronizers cleared. word_ready rises in the first cycle after rst_n deasserts.
- parity0/parity1 each pass through a 2-flop synchronizer (s0, s1). All decisions use s0/s1 only.
- in0/in1 are registered outputs. Never both high.
- FSM states:
  - IDLE: word_ready=1. On word_valid&word_ready: load shift register with word_in, bit counter=0, go NULLCHK.
  - NULLCHK: wait for s0=s1=0, then go DRIVE. Spacer check before the first token.
  - DRIVE: one cycle. Set in1=shreg[MSB] and in0=~shreg[MSB]. Go WAIT_ACK.
  - WAIT_ACK: hold rails.
    - s0 XOR s1: capture last_p1=s1, drop in0=in1=0 next edge, go WAIT_NULL.
    - s0&s1: set err, drop rails, go ERRDRAIN.
  - WAIT_NULL: wait for s0=s1=0.
    - Bit counter = WIDTH-1: go DONE.
    - Otherwise: shift left by 1, increment counter, go DRIVE.
  - DONE: one cycle. result_valid=1, result_p1=last_p1. Go IDLE.
  - ERRDRAIN: rails low. Wait for s0=s1=0, then go IDLE. The word is discarded and result_valid is not asserted.
- Timeout: the counter resets on entry to NULLCHK, WAIT_ACK and WAIT_NULL, and increments each cycle while in one of them. When it reaches TIMEOUT: set err, drop rails, go ERRDRAIN.
- result_p1 holds its value between pulses.
- word_ready=0 in every state except IDLE. word_valid is ignored outside IDLE.
- Minimum token cycle: DRIVE (1) + sync latency (2) + drop (1) + sync latency (2). Minimum word time ≈ 6·WIDTH+2 cycles.
- Async reset mid-token: rails drop immediately; no result is produced for the word in flight.
- A parity rail rising in WAIT_NULL before s0=s1=0 is observed is not an error. The block simply waits for the spacer.

Test Plan:
- Detector model acks 0x03 as WIDTH=8 tokens with bit pattern 0,0,0,0,0,0,1,1 -> in0 pulses 6 times then in1 pulses 2 times; result_valid pulses once with result_p1 matching the model's final rail; no cycle has in0&in1.
- Back-to-back words 0xFF then 0x00 with word_valid held high -> second word accepted only after result_valid (word_ready=0 throughout first word); 16 tokens total, in the correct order.
- Model never acks -> err=1 exactly TIMEOUT+1 cycles after entering WAIT_ACK; rails low; FSM returns to IDLE once parities are low; err stays 1.
- Model raises parity0 and parity1 together on bit 3 -> err=1, no result_valid, word_ready returns after both rails drop.
- rst_n pulsed low while in1 high in WAIT_ACK -> in1=0 asynchronously within the same cycle; after release, word_ready=1 and err=0.
- parity0 left high at word accept -> block holds in NULLCHK with no rail driven until parity0 falls, then drives the first token.

Source files
------------

// File: rtl/dr_word_serializer.sv
// dr_word_serializer: loads a parallel word and sends it MSB-first as
// four-phase return-to-zero dual-rail tokens on in0/in1. The detector's
// parity0/parity1 rails serve as the acknowledge. The block reports the rail
// that acknowledged the final token of each word.
module dr_word_serializer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             in0,
    output logic             in1,
    input  logic             parity0,
    input  logic             parity1,
    output logic             result_valid,
    output logic             result_p1,
    output logic             err
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        NULLCHK,
        DRIVE,
        WAIT_ACK,
        WAIT_NULL,
        DONE,
        ERRDRAIN
    } state_t;

    state_t            state, state_n;
    logic              p0_meta, p1_meta, s0, s1;
    logic [WIDTH-1:0]  shreg;
    logic [CW-1:0]     bitcnt;
    logic [TW-1:0]     tcnt;
    logic              last_p1;

    logic              rail0_n, rail1_n;
    logic              load, shift, capture, set_err, tclr;
    logic              quiet, tmo, waiting;

    assign quiet   = ~s0 & ~s1;
    assign tmo     = (tcnt == TMAX);
    assign waiting = (state == NULLCHK) || (state == WAIT_ACK) || (state == WAIT_NULL);

    // Two-flop synchronizers for the asynchronous acknowledge rails
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_meta <= 1'b0;
            p1_meta <= 1'b0;
            s0      <= 1'b0;
            s1      <= 1'b0;
        end else begin
            p0_meta <= parity0;
            p1_meta <= parity1;
            s0      <= p0_meta;
            s1      <= p1_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state, next rail values and datapath controls
    always_comb begin
        state_n = state;
        rail0_n = in0;
        rail1_n = in1;
        load    = 1'b0;
        shift   = 1'b0;
        capture = 1'b0;
        set_err = 1'b0;
        tclr    = 1'b0;
        case (state)
            IDLE: begin
                if (word_valid && word_ready) begin
                    load    = 1'b1;
                    tclr    = 1'b1;
                    state_n = NULLCHK;
                end
            end
            NULLCHK: begin
                if (quiet) begin
                    state_n = DRIVE;
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_n = ERRDRAIN;
                end
            end
            DRIVE: begin
                rail1_n = shreg[WIDTH-1];
                rail0_n = ~shreg[WIDTH-1];
                tclr    = 1'b1;
                state_n = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (s0 ^ s1) begin
                    capture = 1'b1;
                    rail0_n = 1'b0;
                    rail1_n = 1'b0;
                    tclr    = 1'b1;
                    state_n = WAIT_NULL;
                end else if ((s0 && s1) || tmo) begin
                    set_err = 1'b1;
                    rail0_n = 1'b0;
                    rail1_n = 1'b0;
                    state_n = ERRDRAIN;
                end
            end
            WAIT_NULL: begin
                if (quiet) begin
                    if (bitcnt == LAST_BIT) begin
                        state_n = DONE;
                    end else begin
                        shift   = 1'b1;
                        state_n = DRIVE;
                    end
                end else if (tmo) begin
                    set_err = 1'b1;
                    state_n = ERRDRAIN;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            ERRDRAIN: begin
                rail0_n = 1'b0;
                rail1_n = 1'b0;
                if (quiet) state_n = IDLE;
            end
            default: begin
                rail0_n = 1'b0;
                rail1_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // Shift register, bit counter and captured acknowledge rail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bitcnt  <= '0;
            last_p1 <= 1'b0;
        end else begin
            if (load) begin
                shreg  <= word_in;
                bitcnt <= '0;
            end else if (shift) begin
                shreg  <= shreg << 1;
                bitcnt <= bitcnt + 1'b1;
            end
            if (capture) last_p1 <= s1;
        end
    end

    // Wait-state timeout counter; saturates at TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   tcnt <= '0;
        else if (tclr)                tcnt <= '0;
        else if (waiting && !tmo)     tcnt <= tcnt + 1'b1;
    end

    // Registered outputs, decoded from the upcoming state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in0          <= 1'b0;
            in1          <= 1'b0;
            word_ready   <= 1'b0;
            result_valid <= 1'b0;
            result_p1    <= 1'b0;
            err          <= 1'b0;
        end else begin
            in0          <= rail0_n;
            in1          <= rail1_n;
            word_ready   <= (state_n == IDLE);
            result_valid <= (state_n == DONE);
            if (state_n == DONE) result_p1 <= last_p1;
            if (set_err)         err       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dr_word_serializer.sv
// Bench for dr_word_serializer: a randomly delayed detector model acks every
// token on the rail selected by the running remainder mod 3, so each word's
// final rail must equal (word % 3 == 0).
module tb_dr_word_serializer;

    localparam int W  = 8;
    localparam int TO = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] word_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready, in0, in1, parity0, parity1;
    logic         result_valid, result_p1, err;

    dr_word_serializer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .in0          (in0),
        .in1          (in1),
        .parity0      (parity0),
        .parity1      (parity1),
        .result_valid (result_valid),
        .result_p1    (result_p1),
        .err          (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Detector model: mode 0 normal, 1 never acks, 2 acks both rails on token both_idx
    int   mode = 0;
    int   both_idx = 0;
    int   phase = 0, dly = 0, tokidx = 0, rem = 0;
    logic m_p0 = 1'b0, m_p1 = 1'b0, force_p0 = 1'b0, cur1 = 1'b0;
    bit   toks[$];
    int   both_cnt = 0, rv_cnt = 0;

    assign parity0 = m_p0 | force_p0;
    assign parity1 = m_p1;

    always @(negedge clk) begin
        if (in0 & in1) both_cnt++;
        if (result_valid) rv_cnt++;
        if (word_ready) begin
            rem    = 0;
            tokidx = 0;
        end
        case (phase)
            0: if (in0 | in1) begin
                toks.push_back(in1);
                rem   = (2 * rem + int'(in1)) % 3;
                cur1  = (rem == 0);
                dly   = $urandom_range(3, 0);
                phase = 1;
            end
            1: begin
                if (!(in0 | in1)) phase = 0;
                else if (mode != 1) begin
                    if (dly > 0) dly--;
                    else begin
                        if (mode == 2 && tokidx == both_idx) begin
                            m_p0 = 1'b1;
                            m_p1 = 1'b1;
                        end else if (cur1) m_p1 = 1'b1;
                        else m_p0 = 1'b1;
                        phase = 2;
                    end
                end
            end
            2: if (!(in0 | in1)) begin
                dly   = $urandom_range(3, 0);
                phase = 3;
            end
            default: begin
                if (dly > 0) dly--;
                else begin
                    m_p0 = 1'b0;
                    m_p1 = 1'b0;
                    tokidx++;
                    phase = 0;
                end
            end
        endcase
    end

    task automatic do_reset();
        word_valid = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        bit ok = 0;
        @(negedge clk);
        word_in    = w;
        word_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (word_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 1);
        @(posedge clk);
        #1 word_valid = 1'b0;
    endtask

    task automatic wait_result(output bit seen, output logic p1);
        seen = 0;
        p1   = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1;
                p1   = result_p1;
                break;
            end
        end
    endtask

    function automatic logic [31:0] toks_word();
        logic [31:0] g = '0;
        foreach (toks[i]) g = (g << 1) | 32'(toks[i]);
        return g;
    endfunction

    task automatic run_word(input string tag, input logic [W-1:0] w);
        bit   seen;
        logic p1;
        toks.delete();
        push_word(w);
        wait_result(seen, p1);
        check({tag, "_seen"}, 32'(seen), 1);
        check({tag, "_p1"}, 32'(p1), 32'((int'(w) % 3) == 0));
        check({tag, "_ntok"}, toks.size(), W);
        check({tag, "_bits"}, toks_word(), 32'(w));
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        bit   seen;
        logic p1;
        int   n, early, rv0, rails;

        // Reset values and first-cycle ready
        repeat (2) @(negedge clk);
        check("rst_outs", {26'd0, word_ready, in0, in1, result_valid, result_p1, err}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("ready_after_rst", 32'(word_ready), 1);

        // Directed 0x03 then random words
        run_word("w03", 8'h03);
        for (int k = 0; k < 6; k++) run_word("rand", W'($urandom));

        // Back-to-back 0xFF then 0x00 with word_valid held high
        toks.delete();
        @(negedge clk);
        word_in    = 8'hFF;
        word_valid = 1'b1;
        for (int i = 0; i < 200 && !word_ready; i++) @(negedge clk);
        @(posedge clk);
        #1 word_in = 8'h00;
        seen  = 0;
        early = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (result_valid) seen = 1;
            if (word_ready) begin
                if (!seen) early++;
                else break;
            end
        end
        check("b2b_first_seen", 32'(seen), 1);
        check("b2b_ready_early", early, 0);
        @(posedge clk);
        #1 word_valid = 1'b0;
        wait_result(seen, p1);
        check("b2b_second_seen", 32'(seen), 1);
        check("b2b_p1", 32'(p1), 1);
        check("b2b_ntok", toks.size(), 16);
        check("b2b_bits", toks_word(), 32'h0000FF00);

        // Never acked: timeout
        mode = 1;
        toks.delete();
        push_word(8'hA5);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in0 | in1) begin
                seen = 1;
                break;
            end
        end
        check("tmo_rail_seen", 32'(seen), 1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        check("tmo_cycles", n, TO + 1);
        check("tmo_rails_low", {30'd0, in0, in1}, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (word_ready) begin
                seen = 1;
                break;
            end
        end
        check("tmo_back_idle", 32'(seen), 1);
        check("tmo_err_sticky", 32'(err), 1);
        mode = 0;
        do_reset();
        check("err_cleared", 32'(err), 0);

        // Both parity rails together on token 3
        mode     = 2;
        both_idx = 3;
        rv0      = rv_cnt;
        toks.delete();
        push_word(W'($urandom));
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (err) begin
                seen = 1;
                break;
            end
        end
        check("both_err", 32'(seen), 1);
        seen  = 0;
        early = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (word_ready) begin
                if (parity0 | parity1) early++;
                seen = 1;
                break;
            end
        end
        check("both_back_idle", 32'(seen), 1);
        check("both_ready_early", early, 0);
        check("both_no_result", rv_cnt - rv0, 0);
        check("both_ntok", toks.size(), 4);
        mode = 0;
        do_reset();

        // Asynchronous reset while in1 is driven
        mode = 1;
        push_word(8'h80 | W'($urandom));
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in1) begin
                seen = 1;
                break;
            end
        end
        check("arst_in1_seen", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1 check("arst_in1_drop", 32'(in1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 0;
        repeat (2) @(negedge clk);
        check("arst_ready_err", {30'd0, word_ready, err}, 32'h2);

        // parity0 stuck high at accept: hold in spacer check
        force_p0 = 1'b1;
        toks.delete();
        push_word(8'h5C);
        rails = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (in0 | in1) rails++;
        end
        check("nullchk_no_rail", rails, 0);
        force_p0 = 1'b0;
        wait_result(seen, p1);
        check("nullchk_seen", 32'(seen), 1);
        check("nullchk_p1", 32'(p1), 32'((8'h5C % 3) == 0));
        check("nullchk_bits", toks_word(), 32'h5C);

        check("never_both_rails", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
